// File: rtl/addsub_pkg.sv
// Shared constants for the add/sub scheduler: data width, op codes and FSM states.
package addsub_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_NEG  = 2'b10,
    OP_PASS = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SUB2 = 2'b01,
    HOLD = 2'b10
  } state_e;

endpackage

// File: rtl/adder32.sv
// Plain 32-bit adder with carry out of bit 31; no carry-in.
module adder32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] s,
  output logic        c31
);

  assign {c31, s} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/addsub_sched.sv
// Two-requester round-robin scheduler sharing one adder32 for ADD/SUB/NEG/PASS.
// Optional signed-overflow output res_ovf is built when ADDSUB_OVF_EN is defined.
//
// state | meaning
// IDLE  | no result held, may accept a request
// SUB2  | second adder pass of a SUB (a + t), no request accepted
// HOLD  | result held on res_*, may accept back-to-back when res_ready=1
module addsub_sched
  import addsub_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [1:0]        req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [1:0]        req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              res_id,
  output logic [DATA_W-1:0] res_s,
  output logic              res_c31
`ifdef ADDSUB_OVF_EN
  ,
  output logic              res_ovf
`endif
);

  localparam logic [DATA_W-1:0] ONE = DATA_W'(1);

  state_e            state;
  logic              last;
  logic [DATA_W-1:0] a_hold;
  logic [DATA_W-1:0] t_hold;

  logic              can_accept;
  logic              grant0;
  logic              grant1;
  logic              gid;
  op_e               g_op;
  logic [DATA_W-1:0] g_a;
  logic [DATA_W-1:0] g_b;
  logic [DATA_W-1:0] add_a;
  logic [DATA_W-1:0] add_b;
  logic [DATA_W-1:0] sum;
  logic              carry;

  always_comb begin
    can_accept = rst_n && ((state == IDLE) || ((state == HOLD) && res_ready));
    // last holds the index granted most recently; the other side wins a tie
    grant0     = can_accept && req0_valid && (!req1_valid || last);
    grant1     = can_accept && req1_valid && (!req0_valid || !last);
    gid        = grant1;
    g_op       = grant1 ? op_e'(req1_op) : op_e'(req0_op);
    g_a        = grant1 ? req1_a : req0_a;
    g_b        = grant1 ? req1_b : req0_b;
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_comb begin
    add_a = g_a;
    add_b = '0;
    if (state == SUB2) begin
      add_a = a_hold;
      add_b = t_hold;
    end else begin
      case (g_op)
        OP_ADD:  begin add_a = g_a;  add_b = g_b; end
        OP_SUB:  begin add_a = ~g_b; add_b = ONE; end
        OP_NEG:  begin add_a = ~g_a; add_b = ONE; end
        default: begin add_a = g_a;  add_b = '0;  end
      endcase
    end
  end

  adder32 u_adder (
    .a   (add_a),
    .b   (add_b),
    .s   (sum),
    .c31 (carry)
  );

`ifdef ADDSUB_OVF_EN
  logic b_sign_hold;
  logic ovf_now;
  logic ovf_sub2;

  always_comb begin
    ovf_sub2 = (a_hold[DATA_W-1] != b_sign_hold) && (sum[DATA_W-1] != a_hold[DATA_W-1]);
    case (g_op)
      OP_ADD:  ovf_now = (g_a[DATA_W-1] == g_b[DATA_W-1]) && (sum[DATA_W-1] != g_a[DATA_W-1]);
      OP_NEG:  ovf_now = (g_a == {1'b1, {(DATA_W-1){1'b0}}});
      default: ovf_now = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      b_sign_hold <= 1'b0;
      res_ovf     <= 1'b0;
    end else if (state == SUB2) begin
      res_ovf <= ovf_sub2;
    end else if (grant0 || grant1) begin
      if (g_op == OP_SUB) b_sign_hold <= g_b[DATA_W-1];
      else                res_ovf     <= ovf_now;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      last      <= 1'b1;
      res_valid <= 1'b0;
      res_id    <= 1'b0;
      res_s     <= '0;
      res_c31   <= 1'b0;
      a_hold    <= '0;
      t_hold    <= '0;
    end else begin
      case (state)
        SUB2: begin
          res_s     <= sum;
          res_c31   <= carry;
          res_valid <= 1'b1;
          state     <= HOLD;
        end
        default: begin
          if (grant0 || grant1) begin
            res_id <= gid;
            last   <= gid;
            if (g_op == OP_SUB) begin
              // pass 1 stores t = ~b + 1; result lands after pass 2
              a_hold    <= g_a;
              t_hold    <= sum;
              res_valid <= 1'b0;
              state     <= SUB2;
            end else begin
              res_s     <= (g_op == OP_PASS) ? g_a : sum;
              res_c31   <= (g_op == OP_PASS) ? 1'b0 : carry;
              res_valid <= 1'b1;
              state     <= HOLD;
            end
          end else if ((state == HOLD) && res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_sched.sv
// Self-checking bench for addsub_sched; checks res_ovf too when ADDSUB_OVF_EN is defined.
module tb_addsub_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [1:0]  req0_op, req1_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        res_valid, res_ready, res_id, res_c31;
  logic [31:0] res_s;
`ifdef ADDSUB_OVF_EN
  logic        res_ovf;
`endif

  always #5 clk = ~clk;

  addsub_sched dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
    .res_s(res_s), .res_c31(res_c31)
`ifdef ADDSUB_OVF_EN
    , .res_ovf(res_ovf)
`endif
  );

  int checks = 0;
  int failures = 0;

  // reference model: abstract view of the scheduler
  bit        m_valid, m_sub, m_last, m_id, m_c, m_ovf;
  bit [31:0] m_s;
  bit [31:0] p_s;
  bit        p_c, p_ovf;
  bit        exp_r0, exp_r1, obs_r0, obs_r1;

  task automatic calc(input bit [1:0] op, input bit [31:0] a, input bit [31:0] b,
                      output bit [31:0] s, output bit c, output bit ovf);
    longint sa, sb, r;
    bit [32:0] wide;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'd0: begin wide = {1'b0, a} + {1'b0, b}; s = wide[31:0]; c = wide[32];
              r = sa + sb; ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
      2'd1: begin s = a - b; c = (b != 0) && (a >= b);
              r = sa - sb; ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
      2'd2: begin s = 32'd0 - a; c = (a == 0); ovf = (a == 32'h8000_0000); end
      default: begin s = a; c = 1'b0; ovf = 1'b0; end
    endcase
  endtask

  task automatic model_reset();
    m_valid = 0; m_sub = 0; m_last = 1; m_id = 0; m_c = 0; m_ovf = 0; m_s = 0;
  endtask

  // one clock: sample readies at negedge, advance model at posedge, return #1 after
  task automatic step();
    bit can;
    int w;
    bit [31:0] s;
    bit c, o;
    @(negedge clk);
    obs_r0 = req0_ready;
    obs_r1 = req1_ready;
    can = rst_n && !m_sub && (!m_valid || res_ready);
    w = -1;
    if (can) begin
      if (req0_valid && req1_valid) w = m_last ? 0 : 1;
      else if (req0_valid)          w = 0;
      else if (req1_valid)          w = 1;
    end
    exp_r0 = (w == 0);
    exp_r1 = (w == 1);
    @(posedge clk);
    if (!rst_n) model_reset();
    else if (m_sub) begin
      m_sub = 0; m_valid = 1; m_s = p_s; m_c = p_c; m_ovf = p_ovf;
    end else if (w >= 0) begin
      if (w == 0) calc(req0_op, req0_a, req0_b, s, c, o);
      else        calc(req1_op, req1_a, req1_b, s, c, o);
      m_id = (w == 1); m_last = (w == 1);
      if (((w == 0) ? req0_op : req1_op) == 2'd1) begin
        m_sub = 1; m_valid = 0; p_s = s; p_c = c; p_ovf = o;
      end else begin
        m_valid = 1; m_s = s; m_c = c; m_ovf = o;
      end
    end else if (m_valid && res_ready) m_valid = 0;
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 0; req1_valid = 0; req0_op = 0; req1_op = 0;
    req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; res_ready = 1; idle_inputs();
    req0_valid = 1; req1_valid = 1;
    step(); step();
    checks++;
    if (obs_r0 !== 1'b0 || obs_r1 !== 1'b0) begin
      failures++; $display("FAIL reset_ready: got %b%b want 00", obs_r0, obs_r1);
    end
    checks++;
    if (res_valid !== 0 || res_s !== 0 || res_c31 !== 0 || res_id !== 0) begin
      failures++; $display("FAIL reset_outputs: valid=%b s=%h c=%b id=%b want 0", res_valid, res_s, res_c31, res_id);
    end
    idle_inputs();
    rst_n = 1;
    step();
  endtask

  task automatic test_add();
    req0_valid = 1; req0_op = 2'd0; req0_a = 5; req0_b = 7; res_ready = 1;
    step();
    checks++;
    if (obs_r0 !== 1 || obs_r1 !== 0) begin
      failures++; $display("FAIL add_ready: got %b%b want 10", obs_r0, obs_r1);
    end
    checks++;
    if (res_valid !== 1 || res_s !== 32'd12 || res_c31 !== 0 || res_id !== 0) begin
      failures++; $display("FAIL add_result: valid=%b s=%h c=%b id=%b want 1 0000000c 0 0", res_valid, res_s, res_c31, res_id);
    end
    idle_inputs();
    step();
  endtask

  task automatic test_sub();
    req1_valid = 1; req1_op = 2'd1; req1_a = 3; req1_b = 5; res_ready = 1;
    step();
    checks++;
    if (obs_r1 !== 1 || res_valid !== 0) begin
      failures++; $display("FAIL sub_grant: ready1=%b valid=%b want 1 0", obs_r1, res_valid);
    end
    req0_valid = 1; req0_op = 2'd0; req1_op = 2'd0;
    step();
    checks++;
    if (obs_r0 !== 0 || obs_r1 !== 0) begin
      failures++; $display("FAIL sub2_no_ready: got %b%b want 00", obs_r0, obs_r1);
    end
    checks++;
    if (res_valid !== 1 || res_s !== 32'hFFFF_FFFE || res_id !== 1 || res_c31 !== 0) begin
      failures++; $display("FAIL sub_result: valid=%b s=%h id=%b c=%b want 1 fffffffe 1 0", res_valid, res_s, res_id, res_c31);
    end
    idle_inputs();
    step();
  endtask

  task automatic test_alternate();
    bit [3:0] seen;
    req0_valid = 1; req1_valid = 1; req0_op = 2'd0; req1_op = 2'd3;
    res_ready = 1;
    for (int i = 0; i < 4; i++) begin
      req0_a = $urandom; req0_b = $urandom; req1_a = $urandom;
      step();
      seen[i] = obs_r1;
      checks++;
      if ((obs_r0 ^ obs_r1) !== 1'b1 || res_id !== m_id || res_s !== m_s || res_c31 !== m_c) begin
        failures++; $display("FAIL alt_step%0d: r=%b%b id=%b s=%h want id=%b s=%h", i, obs_r0, obs_r1, res_id, res_s, m_id, m_s);
      end
    end
    checks++;
    if (seen !== 4'b1010) begin
      failures++; $display("FAIL alt_order: grants(bit0 first)=%b want 1010", seen);
    end
    idle_inputs();
    step();
  endtask

  task automatic test_wrap();
    req0_valid = 1; req0_op = 2'd2; req0_a = 32'h8000_0000; res_ready = 1;
    step();
    checks++;
    if (res_s !== 32'h8000_0000 || res_c31 !== 0) begin
      failures++; $display("FAIL neg_min: s=%h c=%b want 80000000 0", res_s, res_c31);
    end
`ifdef ADDSUB_OVF_EN
    checks++;
    if (res_ovf !== 1) begin failures++; $display("FAIL neg_min_ovf: got %b want 1", res_ovf); end
`endif
    req0_op = 2'd0; req0_a = 32'hFFFF_FFFF; req0_b = 1;
    step();
    checks++;
    if (res_s !== 0 || res_c31 !== 1) begin
      failures++; $display("FAIL add_wrap: s=%h c=%b want 00000000 1", res_s, res_c31);
    end
`ifdef ADDSUB_OVF_EN
    checks++;
    if (res_ovf !== 0) begin failures++; $display("FAIL add_wrap_ovf: got %b want 0", res_ovf); end
`endif
    req0_op = 2'd2; req0_a = 0;
    step();
    checks++;
    if (res_s !== 0 || res_c31 !== 1) begin
      failures++; $display("FAIL neg_zero: s=%h c=%b want 00000000 1", res_s, res_c31);
    end
    idle_inputs();
    step();
  endtask

  task automatic test_stall();
    bit [31:0] s0;
    bit c0, id0;
    req0_valid = 1; req0_op = 2'd0; req0_a = 32'h1234_5678; req0_b = 32'h1111_1111; res_ready = 1;
    step();
    s0 = 32'h2345_6789; c0 = 0; id0 = 0;
    res_ready = 0;
    req0_a = $urandom; req0_b = $urandom;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (obs_r0 !== 0 || res_valid !== 1 || res_s !== s0 || res_c31 !== c0 || res_id !== id0) begin
        failures++; $display("FAIL stall_%0d: r0=%b valid=%b s=%h want 0 1 %h", i, obs_r0, res_valid, res_s, s0);
      end
    end
    res_ready = 1;
    step();
    checks++;
    if (obs_r0 !== 1 || res_s !== m_s) begin
      failures++; $display("FAIL stall_release: r0=%b s=%h want 1 %h", obs_r0, res_s, m_s);
    end
    idle_inputs();
    step();
  endtask

  task automatic test_reset_mid();
    req1_valid = 1; req1_op = 2'd3; req1_a = 9; res_ready = 1;
    step();
    idle_inputs();
    req0_valid = 1; req0_op = 2'd1; req0_a = 100; req0_b = 1;
    step();
    idle_inputs();
    rst_n = 0;
    step();
    checks++;
    if (res_valid !== 0 || res_s !== 0 || res_c31 !== 0 || res_id !== 0) begin
      failures++; $display("FAIL midsub_reset: valid=%b s=%h want 0 00000000", res_valid, res_s);
    end
    rst_n = 1;
    req0_valid = 1; req1_valid = 1; req0_op = 2'd3; req1_op = 2'd3;
    step();
    checks++;
    if (obs_r0 !== 1 || obs_r1 !== 0) begin
      failures++; $display("FAIL post_reset_tie: got %b%b want 10", obs_r0, obs_r1);
    end
    idle_inputs();
    step();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst_n      = ($urandom_range(0, 49) != 0);
      req0_valid = $urandom; req1_valid = $urandom; res_ready = ($urandom_range(0, 3) != 0);
      req0_op = 2'($urandom); req1_op = 2'($urandom);
      req0_a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      req0_b = $urandom; req1_a = $urandom;
      req1_b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      step();
      checks++;
      if (obs_r0 !== exp_r0 || obs_r1 !== exp_r1 || res_valid !== m_valid || res_s !== m_s ||
          res_c31 !== m_c || res_id !== m_id) begin
        failures++;
        $display("FAIL random_%0d: r=%b%b v=%b s=%h c=%b id=%b want r=%b%b v=%b s=%h c=%b id=%b",
                 i, obs_r0, obs_r1, res_valid, res_s, res_c31, res_id,
                 exp_r0, exp_r1, m_valid, m_s, m_c, m_id);
      end
`ifdef ADDSUB_OVF_EN
      checks++;
      if (res_valid && res_ovf !== m_ovf) begin
        failures++; $display("FAIL random_ovf_%0d: got %b want %b", i, res_ovf, m_ovf);
      end
`endif
    end
  endtask

  initial begin
    model_reset();
    rst_n = 0; res_ready = 0; idle_inputs();
    test_reset();
    test_add();
    test_sub();
    test_alternate();
    test_wrap();
    test_stall();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/addsub_sched.md
ADDSUB_SCHED -- requirements
Module: addsub_sched

Interface
REQ-001 SHALL have no parameters; data width fixed at 32.
REQ-002 SHALL have port: clk  input  1  rising-edge clock.
REQ-003 SHALL have port: rst_n  input  1  one clock; reset is synchronous and active-low.
REQ-004 SHALL have port: req0_valid / req1_valid  input  1  requester n has an operation pending.
REQ-005 SHALL have port: req0_ready / req1_ready  output  1  requester n operation accepted this cycle.
REQ-006 SHALL have port: req0_op / req1_op  input  2  00 ADD a+b, 01 SUB a-b, 10 NEG -a, 11 PASS a.
REQ-007 SHALL have port: req0_a, req0_b / req1_a, req1_b  input  32  operands.
REQ-008 SHALL have port: res_valid  output  1  result register holds a result.
REQ-009 SHALL have port: res_ready  input  1  consumer takes the result.
REQ-010 SHALL have port: res_id  output  1  requester index that produced the result.
REQ-011 SHALL have port: res_s  output  32  result.
REQ-012 SHALL have port: res_c31  output  1  carry out of bit 31 from the final adder pass; 0 for PASS.

Function
REQ-013 SHALL share exactly one adder32 instance (A, B, S, C31; no carry-in) among all operations.
REQ-014 SHALL implement FSM states IDLE, SUB2, HOLD.
REQ-015 SHALL accept a request, via ready, only in IDLE, or in HOLD with res_ready=1 (back-to-back).
REQ-016 SHALL grant round-robin: if both valid, the requester not granted last wins; after reset req0 wins the first tie.
REQ-017 SHALL assert at most one of req0_ready/req1_ready per cycle; ready depends on valid, state and res_ready only.
REQ-018 SHALL, on ADD grant, drive adder A=a, B=b and load res_s/res_c31 at the next edge; state goes to HOLD; latency 1 cycle.
REQ-019 SHALL, on NEG grant, drive A=~a, B=1; latency 1 cycle.
REQ-020 SHALL, on PASS grant, load res_s=a with res_c31=0; latency 1 cycle.
REQ-021 SHALL, on SUB grant, capture a; pass 1 computes t=~b+1 into an internal register (state SUB2); pass 2 computes a+t into res_s with res_c31 from pass 2; latency 2 cycles.
REQ-022 SHALL accept no request while in SUB2.
REQ-023 SHALL go from HOLD to IDLE on res_ready=1 with no grant; SHALL hold res_* stable while res_valid=1 and res_ready=0.
REQ-024 SHALL assert res_valid exactly in HOLD; res_id equals the granted index.
REQ-025 SHALL handle wrap-around modulo 2^32 (e.g. NEG 0x80000000 = 0x80000000; NEG 0 = 0 with c31=1).
REQ-026 SHALL ignore op/operands of requesters not granted; operands SHALL be sampled only on the grant cycle.

Reset
REQ-027 SHALL, on rst_n=0 at a clock edge, force state IDLE, res_valid=0, res_id=0, res_s=0, res_c31=0, RR pointer "last=1", all readies 0 during reset.
REQ-028 SHALL discard any in-flight SUB or held result when reset is asserted mid-operation.

Configuration
REQ-029 SHALL, with macro ADDSUB_OVF_EN defined, add output res_ovf (1 bit): signed overflow of the completed op (ADD/SUB per operand/result signs; NEG when a=0x80000000; PASS 0), registered with res_s, reset 0.
REQ-030 SHALL, without ADDSUB_OVF_EN, omit res_ovf port and logic entirely; all other behaviour identical.

Structure
REQ-031 SHALL place op encodings (OP_ADD, OP_SUB, OP_NEG, OP_PASS), state encodings and width constant in shared package addsub_pkg.
REQ-032 SHALL instantiate the existing adder32 as its only sub-module; operand muxing and FSM stay in addsub_sched.

Verification
REQ-033 SHALL cover: req0 ADD a=5 b=7 -> req0_ready same cycle, res_valid next cycle, res_s=12, res_c31=0, res_id=0.
REQ-034 SHALL cover: req1 SUB a=3 b=5 -> res_valid after 2 cycles, res_s=0xFFFFFFFE, res_id=1; no ready during SUB2.
REQ-035 SHALL cover: both valid continuously, res_ready=1 -> grants alternate 0,1,0,1 starting with req0.
REQ-036 SHALL cover: NEG a=0x80000000 with ADDSUB_OVF_EN -> res_s=0x80000000, res_ovf=1; ADD 0xFFFFFFFF+1 -> res_s=0, res_c31=1, res_ovf=0.
REQ-037 SHALL cover: res_ready=0 for 5 cycles while req0 valid -> res_* stable, req0_ready=0 until res_ready=1.
REQ-038 SHALL cover: rst_n=0 during SUB2 -> next cycle IDLE, res_valid=0, res_s=0; first subsequent tie granted to req0.
